// File: rtl/snake_pkg.sv
// ============================================================================
// snake_pkg : shared types and sizes for the snake game apple/collision path
// Rev 1.0
// ============================================================================
`default_nettype none

package snake_pkg;

  localparam int         MAX_LENGTH = 30;
  localparam int         NUM_WALLS  = 25;
  localparam logic [7:0] WALL_EMPTY = 8'h00;

  typedef logic [3:0] coord_t;

  typedef struct packed {
    coord_t y;
    coord_t x;
  } cell_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PICK   = 3'd1,
    CHECK  = 3'd2,
    SCAN   = 3'd3,
    COMMIT = 3'd4,
    FAIL   = 3'd5
  } spawn_state_t;

endpackage

`default_nettype wire

// File: rtl/spawn_lfsr.sv
// ============================================================================
// spawn_lfsr : 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, source of candidate cells
// Rev 1.0
// ============================================================================
`default_nettype none

module spawn_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [7:0] state_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (en_i) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/apple_spawner.sv
// ============================================================================
// apple_spawner : owns both apple positions; on an eat request searches for a
//                 free interior cell (random tries, then linear scan) and publishes it
// Rev 1.0
// ============================================================================
`default_nettype none

module apple_spawner #(
  parameter int         MAX_LENGTH = snake_pkg::MAX_LENGTH,
  parameter int         NUM_WALLS  = snake_pkg::NUM_WALLS,
  parameter int         MAX_TRIES  = 16,
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  parameter logic [7:0] INIT_A1    = 8'h48,
  parameter logic [7:0] INIT_A2    = 8'h4B
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              goodCollision,
  input  logic                              good_collision2,
  input  logic [3:0]                        borderXMin,
  input  logic [3:0]                        borderXMax,
  input  logic [3:0]                        borderYMin,
  input  logic [3:0]                        borderYMax,
  input  logic [3:0]                        snakeHeadX,
  input  logic [3:0]                        snakeHeadY,
  input  logic [3:0]                        snakeArrayX [MAX_LENGTH],
  input  logic [3:0]                        snakeArrayY [MAX_LENGTH],
  input  logic [$clog2(MAX_LENGTH+1)-1:0]   snake_len,
  input  logic [7:0]                        wall_array [NUM_WALLS],
  output logic [3:0]                        AppleX,
  output logic [3:0]                        AppleY,
  output logic [3:0]                        AppleX2,
  output logic [3:0]                        AppleY2,
  output logic                              busy,
  output logic                              spawn_done,
  output logic                              spawn_fail
);

  import snake_pkg::*;

  localparam int TRY_W = $clog2(MAX_TRIES);

  spawn_state_t     state_q, state_d;
  cell_t            apple1_q, apple1_d, apple2_q, apple2_d;
  cell_t            cand_q, cand_d, cursor_q, cursor_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [7:0]       scan_cnt_q, scan_cnt_d;
  logic             prev1_q, prev2_q, rise1_q, rise2_q;
  logic             pend1_q, pend1_d, pend2_q, pend2_d;
  logic             tgt2_q, tgt2_d;
  logic             busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [7:0]       lfsr_state;
  cell_t            eval_cell, other_apple;
  logic             eval_free;

  spawn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en_i    (1'b1),
    .state_o (lfsr_state)
  );

  function automatic logic cell_free(input cell_t c, input cell_t other);
    logic ok;
    ok = (c.x > borderXMin) && (c.x < borderXMax) &&
         (c.y > borderYMin) && (c.y < borderYMax);
    if (c.x == snakeHeadX && c.y == snakeHeadY) ok = 1'b0;
    for (int i = 0; i < MAX_LENGTH; i++) begin
      if (i < int'(snake_len) && c.x == snakeArrayX[i] && c.y == snakeArrayY[i]) ok = 1'b0;
    end
    for (int i = 0; i < NUM_WALLS; i++) begin
      if (wall_array[i] != WALL_EMPTY && wall_array[i] == 8'(c)) ok = 1'b0;
    end
    if (c == other) ok = 1'b0;
    return ok;
  endfunction

  // The cell under test is the random candidate, or the scan cursor once scanning.
  assign eval_cell   = (state_q == SCAN) ? cursor_q : cand_q;
  assign other_apple = tgt2_q ? apple1_q : apple2_q;
  assign eval_free   = cell_free(eval_cell, other_apple);

  always_comb begin
    state_d    = state_q;
    apple1_d   = apple1_q;
    apple2_d   = apple2_q;
    cand_d     = cand_q;
    cursor_d   = cursor_q;
    tries_d    = tries_q;
    scan_cnt_d = scan_cnt_q;
    tgt2_d     = tgt2_q;
    done_d     = 1'b0;
    fail_d     = 1'b0;
    pend1_d    = pend1_q | rise1_q;
    pend2_d    = pend2_q | rise2_q;

    case (state_q)
      IDLE: begin
        if (pend1_q) begin
          tgt2_d  = 1'b0;
          pend1_d = rise1_q;
          state_d = PICK;
        end else if (pend2_q) begin
          tgt2_d  = 1'b1;
          pend2_d = rise2_q;
          state_d = PICK;
        end
      end
      PICK: begin
        cand_d  = cell_t'(lfsr_state);
        state_d = CHECK;
      end
      CHECK, SCAN: begin
        if (eval_free) begin
          if (tgt2_q) apple2_d = eval_cell;
          else        apple1_d = eval_cell;
          done_d  = 1'b1;
          state_d = COMMIT;
        end else if (state_q == CHECK) begin
          if (int'(tries_q) < MAX_TRIES - 1) begin
            tries_d = tries_q + TRY_W'(1);
            state_d = PICK;
          end else begin
            cursor_d.x = borderXMin + 4'd1;
            cursor_d.y = borderYMin + 4'd1;
            scan_cnt_d = 8'd0;
            state_d    = SCAN;
          end
        end else if (scan_cnt_q == 8'd255) begin
          fail_d  = 1'b1;
          state_d = FAIL;
        end else begin
          scan_cnt_d = scan_cnt_q + 8'd1;
          // 5-bit compares keep the wrap test correct for cursor values near 15.
          if ({1'b0, cursor_q.x} + 5'd1 >= {1'b0, borderXMax}) begin
            cursor_d.x = borderXMin + 4'd1;
            if ({1'b0, cursor_q.y} + 5'd1 >= {1'b0, borderYMax}) cursor_d.y = borderYMin + 4'd1;
            else                                                 cursor_d.y = cursor_q.y + 4'd1;
          end else begin
            cursor_d.x = cursor_q.x + 4'd1;
          end
        end
      end
      COMMIT, FAIL: begin
        tries_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || pend1_d || pend2_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      apple1_q   <= cell_t'(INIT_A1);
      apple2_q   <= cell_t'(INIT_A2);
      cand_q     <= '0;
      cursor_q   <= '0;
      tries_q    <= '0;
      scan_cnt_q <= '0;
      tgt2_q     <= 1'b0;
      prev1_q    <= 1'b0;
      prev2_q    <= 1'b0;
      rise1_q    <= 1'b0;
      rise2_q    <= 1'b0;
      pend1_q    <= 1'b0;
      pend2_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      apple1_q   <= apple1_d;
      apple2_q   <= apple2_d;
      cand_q     <= cand_d;
      cursor_q   <= cursor_d;
      tries_q    <= tries_d;
      scan_cnt_q <= scan_cnt_d;
      tgt2_q     <= tgt2_d;
      prev1_q    <= goodCollision;
      prev2_q    <= good_collision2;
      rise1_q    <= goodCollision & ~prev1_q;
      rise2_q    <= good_collision2 & ~prev2_q;
      pend1_q    <= pend1_d;
      pend2_q    <= pend2_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  assign AppleX     = apple1_q.x;
  assign AppleY     = apple1_q.y;
  assign AppleX2    = apple2_q.x;
  assign AppleY2    = apple2_q.y;
  assign busy       = busy_q;
  assign spawn_done = done_q;
  assign spawn_fail = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_apple_spawner.sv
// ============================================================================
// tb_apple_spawner : directed self-checking bench for apple_spawner
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_apple_spawner;

  localparam int ML = 30;
  localparam int NW = 25;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          gc1 = 1'b0;
  logic          gc2 = 1'b0;
  logic [3:0]    bxmin, bxmax, bymin, bymax;
  logic [3:0]    hx, hy;
  logic [3:0]    sx [ML];
  logic [3:0]    sy [ML];
  logic [LW-1:0] slen;
  logic [7:0]    walls [NW];
  logic [3:0]    ax, ay, ax2, ay2;
  logic          busy, spawn_done, spawn_fail;

  int checks = 0;
  int errors = 0;

  logic [7:0] m;

  apple_spawner dut (
    .clk             (clk),
    .rst             (rst),
    .goodCollision   (gc1),
    .good_collision2 (gc2),
    .borderXMin      (bxmin),
    .borderXMax      (bxmax),
    .borderYMin      (bymin),
    .borderYMax      (bymax),
    .snakeHeadX      (hx),
    .snakeHeadY      (hy),
    .snakeArrayX     (sx),
    .snakeArrayY     (sy),
    .snake_len       (slen),
    .wall_array      (walls),
    .AppleX          (ax),
    .AppleY          (ay),
    .AppleX2         (ax2),
    .AppleY2         (ay2),
    .busy            (busy),
    .spawn_done      (spawn_done),
    .spawn_fail      (spawn_fail)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] stepn(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = step(r);
    return r;
  endfunction

  // Reference sequence of x^8+x^6+x^5+x^4+1 from seed A5.
  always @(posedge clk or posedge rst) begin
    if (rst) m <= 8'hA5;
    else     m <= step(m);
  end

  task automatic set_open();
    bxmin = 4'd0; bxmax = 4'd15; bymin = 4'd0; bymax = 4'd15;
    hx = 4'd0; hy = 4'd0; slen = '0;
    for (int i = 0; i < ML; i++) begin sx[i] = 4'd0; sy[i] = 4'd0; end
    for (int i = 0; i < NW; i++) walls[i] = 8'h00;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    set_open();
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({ay, ax} !== 8'h48) begin errors++; $display("FAIL reset_a1 got %h exp 48", {ay, ax}); end
    checks++; if ({ay2, ax2} !== 8'h4B) begin errors++; $display("FAIL reset_a2 got %h exp 4b", {ay2, ax2}); end
    checks++; if ({busy, spawn_done, spawn_fail} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, spawn_done, spawn_fail}); end
    checks++; if (dut.u_lfsr.state_o !== 8'hA5) begin errors++; $display("FAIL reset_lfsr got %h exp a5", dut.u_lfsr.state_o); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dut.u_lfsr.state_o !== 8'h4A) begin errors++; $display("FAIL lfsr_step got %h exp 4a", dut.u_lfsr.state_o); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({ay, ax, ay2, ax2} !== 16'h484B) begin errors++; $display("FAIL midcycle_reset got %h exp 484b", {ay, ax, ay2, ax2}); end
    checks++; if (dut.u_lfsr.state_o !== 8'hA5) begin errors++; $display("FAIL midcycle_lfsr got %h exp a5", dut.u_lfsr.state_o); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_first_try();
    logic [7:0] c;
    int hit, waitc;
    set_open();
    @(negedge clk);
    c = stepn(m, 3);
    waitc = 0;
    while (!(c[3:0] >= 4'd1 && c[3:0] <= 4'd14 && c[7:4] >= 4'd1 && c[7:4] <= 4'd14 && c != 8'h4B) && waitc < 300) begin
      @(negedge clk); c = stepn(m, 3); waitc++;
    end
    gc1 = 1'b1;
    hit = -1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (spawn_done && hit < 0) hit = cyc;
    end
    gc1 = 1'b0;
    checks++; if (hit !== 4) begin errors++; $display("FAIL first_latency got %0d exp 4", hit); end
    checks++; if ({ay, ax} !== c) begin errors++; $display("FAIL first_apple got %h exp %h", {ay, ax}, c); end
    checks++; if ({ay2, ax2} !== 8'h4B) begin errors++; $display("FAIL first_a2_kept got %h exp 4b", {ay2, ax2}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f1, f2, s1, s2;
    int np;
    set_open();
    np = 0; f1 = '0; f2 = '0; s1 = '0; s2 = '0;
    @(negedge clk);
    gc1 = 1'b1; gc2 = 1'b1;
    for (int cyc = 0; cyc < 300 && np < 2; cyc++) begin
      @(negedge clk);
      if (spawn_done) begin
        np++;
        if (np == 1) begin f1 = {ay, ax}; f2 = {ay2, ax2}; end
        else         begin s1 = {ay, ax}; s2 = {ay2, ax2}; end
      end
    end
    gc1 = 1'b0; gc2 = 1'b0;
    checks++; if (np !== 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", np); end
    checks++; if (f2 !== 8'h4B) begin errors++; $display("FAIL b2b_a1_first got a2=%h exp 4b", f2); end
    checks++; if (s1 !== f1) begin errors++; $display("FAIL b2b_a1_stable got %h exp %h", s1, f1); end
    checks++; if (s1 === s2) begin errors++; $display("FAIL b2b_distinct got %h and %h exp different", s1, s2); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_low got %b exp 0", busy); end
  endtask

  task automatic test_scan_fallback();
    int idx, hit, waitc;
    logic clash;
    set_open();
    bxmin = 4'd2; bxmax = 4'd11; bymin = 4'd4; bymax = 4'd12;
    idx = 0;
    for (int y = 5; y <= 11; y++) begin
      for (int x = 3; x <= 10; x++) begin
        if (!(x == 7 && y == 9)) begin
          if (idx == 0)       begin hx = 4'(x); hy = 4'(y); end
          else if (idx <= 30) begin sx[idx-1] = 4'(x); sy[idx-1] = 4'(y); end
          else                walls[idx-31] = {4'(y), 4'(x)};
          idx++;
        end
      end
    end
    slen = LW'(30);
    waitc = 0;
    do begin
      @(negedge clk);
      clash = 1'b0;
      for (int k = 0; k < 16; k++) if (stepn(m, 3 + 2 * k) == 8'h97) clash = 1'b1;
      waitc++;
    end while (clash && waitc < 300);
    gc1 = 1'b1;
    hit = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (spawn_done && hit < 0) hit = cyc;
      if (cyc == 40 && dut.state_q !== snake_pkg::SCAN) begin
        errors++; $display("FAIL scan_entered got state %0d exp SCAN", dut.state_q);
      end
    end
    checks++;
    gc1 = 1'b0;
    checks++; if (hit !== 71) begin errors++; $display("FAIL scan_latency got %0d exp 71", hit); end
    checks++; if ({ay, ax} !== 8'h97) begin errors++; $display("FAIL scan_apple got %h exp 97", {ay, ax}); end
  endtask

  task automatic test_spawn_fail();
    int hit, nd;
    pulse_reset();
    set_open();
    bxmin = 4'd5; bxmax = 4'd6;
    @(negedge clk);
    gc1 = 1'b1;
    hit = -1; nd = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (spawn_fail && hit < 0) hit = cyc;
      if (spawn_done) nd++;
    end
    gc1 = 1'b0;
    checks++; if (hit !== 290) begin errors++; $display("FAIL fail_latency got %0d exp 290", hit); end
    checks++; if (nd !== 0) begin errors++; $display("FAIL fail_no_done got %0d exp 0", nd); end
    checks++; if ({ay, ax, ay2, ax2} !== 16'h484B) begin errors++; $display("FAIL fail_apples got %h exp 484b", {ay, ax, ay2, ax2}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fail_busy got %b exp 0", busy); end
  endtask

  task automatic test_hold_and_abort();
    int nd;
    set_open();
    @(negedge clk);
    gc1 = 1'b1;
    nd = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 9) gc1 = 1'b0;
      if (spawn_done) nd++;
    end
    checks++; if (nd !== 1) begin errors++; $display("FAIL hold_single got %0d exp 1", nd); end
    checks++; if ({ay2, ax2} !== 8'h4B) begin errors++; $display("FAIL hold_a2 got %h exp 4b", {ay2, ax2}); end
    bxmin = 4'd5; bxmax = 4'd6;
    @(negedge clk);
    gc1 = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b exp 1", busy); end
    gc1 = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if ({ay, ax, ay2, ax2} !== 16'h484B) begin errors++; $display("FAIL abort_apples got %h exp 484b", {ay, ax, ay2, ax2}); end
    checks++; if ({busy, spawn_done, spawn_fail} !== 3'b000) begin errors++; $display("FAIL abort_flags got %b exp 000", {busy, spawn_done, spawn_fail}); end
    @(negedge clk); rst = 1'b0;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (spawn_done || spawn_fail || busy) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_quiet got %0d exp 0", nd); end
  endtask

  initial begin
    test_reset();
    test_first_try();
    test_back_to_back();
    test_scan_fallback();
    test_spawn_fail();
    test_hold_and_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
